// File: rtl/rr_sel_arbiter_pkg.sv
// Shared definitions for the round-robin select arbiter: state encoding and
// a one-hot helper used to build the grant vector from the winning index.
package arb_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_BUSY = ST_BUSY
  } state_t;

  localparam int ONEHOT_W = 32;

  function automatic logic [ONEHOT_W-1:0] onehot(input int unsigned idx);
    return ONEHOT_W'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_sel_arbiter_if.sv
// Handshake and select bundle between the requesting sources, the arbiter
// and the downstream 4:1 mux; slave is the arbiter side.
interface rr_sel_arbiter_if #(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
);
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_last;
  logic [N-1:0]     in_ready;
  logic             out_ready;
  logic             out_valid;
  logic             out_last;
  logic [SEL_W-1:0] sel;
  logic [N-1:0]     grant;
  logic             busy;

  modport slave (
    input  in_valid, in_last, out_ready,
    output in_ready, out_valid, out_last, sel, grant, busy
  );

  modport master (
    output in_valid, in_last, out_ready,
    input  in_ready, out_valid, out_last, sel, grant, busy
  );
endinterface

// File: rtl/rr_sel_arbiter_pick.sv
// Combinational rotating-priority encoder: first asserted request found when
// searching ptr, ptr+1, ... modulo N.
module rr_pick #(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Walk from the lowest priority upward so the last hit is the winner;
  // the index wraps for free because N is a power of two.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter driving the select of a 4:1 mux; locks one source per
// packet (or per MAX_HOLD beats) and forwards its valid/ready handshake.
//   state  | meaning
//   S_IDLE | no owner, grant=0; arbitrate among in_valid starting at ptr
//   S_BUSY | owner locked; sel/grant frozen until last beat or hold limit
module rr_sel_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int SEL_W    = $clog2(N),
  parameter int MAX_HOLD = 16
) (
  input logic              clk,
  input logic              rst,
  rr_sel_arbiter_if.slave  bus
);

  localparam int CNT_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_SAT   = (MAX_HOLD == 0) ? '1 : CNT_W'(MAX_HOLD);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] sel_r;
  logic [N-1:0]     grant_r;
  logic [CNT_W-1:0] beat_cnt;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic             out_valid_w;
  logic             out_last_w;
  logic             xfer;
  logic             hold_hit;
  logic             release_w;

  rr_pick #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_pick (
    .req (bus.in_valid),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign out_valid_w = |(bus.in_valid & grant_r);
  assign out_last_w  = |(bus.in_last & bus.in_valid & grant_r);
  assign xfer        = out_valid_w & bus.out_ready;
  // beat_cnt counts beats already taken, so HOLD_LAST marks the MAX_HOLD-th beat
  assign hold_hit    = (MAX_HOLD != 0) && (beat_cnt == HOLD_LAST);
  assign release_w   = xfer & (out_last_w | hold_hit);

  assign bus.in_ready  = grant_r & {N{bus.out_ready}};
  assign bus.out_valid = out_valid_w;
  assign bus.out_last  = out_last_w;
  assign bus.sel       = sel_r;
  assign bus.grant     = grant_r;
  assign bus.busy      = (state == S_BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      sel_r    <= '0;
      grant_r  <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            state    <= S_BUSY;
            sel_r    <= pick_idx;
            grant_r  <= N'(onehot(32'(pick_idx)));
            beat_cnt <= '0;
          end
        end
        S_BUSY: begin
          if (xfer && (beat_cnt != CNT_SAT)) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
          // sel is left alone so the mux keeps pointing at the last owner
          if (release_w) begin
            state   <= S_IDLE;
            grant_r <= '0;
            ptr     <= sel_r + SEL_W'(1);
          end
        end
        default: begin
          state   <= S_IDLE;
          grant_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Scoreboard bench for rr_sel_arbiter: directed packets per source, expected
// grants/beats queued up front and checked by a negedge monitor.
module tb_rr_sel_arbiter;
  localparam int N = 4;

  typedef struct {
    int src;
    bit last;
  } xfer_t;

  logic clk;
  logic rst;

  rr_sel_arbiter_if #(.N(N)) bus ();

  rr_sel_arbiter #(.N(N), .MAX_HOLD(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    vectors     = 0;
  int    miscompares = 0;
  bit    src_q[N][$];
  bit    hold[N];
  int    exp_grant[$];
  xfer_t exp_xfer[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_pkt(input int s, input int beats, input bit with_last);
    for (int b = 0; b < beats; b++) begin
      src_q[s].push_back(with_last && (b == beats - 1));
      exp_xfer.push_back('{src: s, last: with_last && (b == beats - 1)});
    end
  endtask

  function automatic bit all_drained();
    bit d = (exp_grant.size() == 0) && (exp_xfer.size() == 0) && !bus.busy;
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) d = 1'b0;
    return d;
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (!all_drained() && n < 300) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= 300) begin
      miscompares++;
      $display("FAIL %s_timeout: grants left %0d beats left %0d busy %0b", name,
               exp_grant.size(), exp_xfer.size(), bus.busy);
    end
  endtask

  // source driver: pops a beat after it was accepted, then presents the next
  initial begin
    logic [N-1:0] acc;
    logic [N-1:0] iv;
    logic [N-1:0] il;
    bus.in_valid = '0;
    bus.in_last  = '0;
    forever begin
      @(negedge clk);
      acc = rst ? '0 : (bus.in_valid & bus.in_ready);
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        iv[i] = (src_q[i].size() > 0) && !hold[i];
        il[i] = iv[i] && src_q[i][0];
      end
      bus.in_valid = iv;
      bus.in_last  = il;
    end
  end

  // monitor: grants on BUSY entry, frozen select while busy, accepted beats
  initial begin
    bit           busy_q = 1'b0;
    logic [1:0]   sel_q  = '0;
    logic [N-1:0] grant_q = '0;
    int           e;
    xfer_t        x;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_q = 1'b0;
      end else begin
        if (bus.busy && !busy_q) begin
          if (exp_grant.size() == 0) begin
            chk("unexpected_grant", 32'(bus.grant), 32'h0);
          end else begin
            e = exp_grant.pop_front();
            chk("grant_sel", 32'(bus.sel), 32'(e));
            chk("grant_onehot", 32'(bus.grant), 32'h1 << e);
          end
        end else if (bus.busy) begin
          chk("sel_stable", 32'(bus.sel), 32'(sel_q));
          chk("grant_stable", 32'(bus.grant), 32'(grant_q));
        end else begin
          chk("idle_grant_zero", 32'(bus.grant), 32'h0);
        end
        if (!bus.out_ready) chk("in_ready_gated", 32'(bus.in_ready), 32'h0);
        if (bus.out_valid && bus.out_ready) begin
          if (exp_xfer.size() == 0) begin
            chk("unexpected_beat_sel", 32'(bus.sel), 32'hff);
          end else begin
            x = exp_xfer.pop_front();
            chk("beat_sel", 32'(bus.sel), 32'(x.src));
            chk("beat_last", 32'(bus.out_last), 32'(x.last));
            chk("beat_in_ready", 32'(bus.in_ready), 32'h1 << x.src);
          end
        end
        busy_q  = bus.busy;
        sel_q   = bus.sel;
        grant_q = bus.grant;
      end
    end
  end

  initial begin
    bit [4:0] pat = 5'b10101;
    for (int i = 0; i < N; i++) hold[i] = 1'b0;
    rst           = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_sel", 32'(bus.sel), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_last", 32'(bus.out_last), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
    rst           = 1'b0;
    bus.out_ready = 1'b1;

    // 1: lone single-beat request from source 2, one-cycle arbitration
    exp_grant.push_back(2);
    push_pkt(2, 1, 1'b1);
    tick();
    chk("t1_not_yet_busy", 32'(bus.busy), 32'h0);
    tick();
    chk("t1_busy", 32'(bus.busy), 32'h1);
    chk("t1_grant", 32'(bus.grant), 32'h4);
    wait_idle("t1");
    // ptr is now 3, so 3 beats 0 when both ask together
    exp_grant.push_back(3);
    exp_grant.push_back(0);
    push_pkt(3, 1, 1'b1);
    push_pkt(0, 1, 1'b1);
    wait_idle("t1_ptr");

    rst = 1'b1;
    tick();
    rst = 1'b0;

    // 2: all four requesting, single-beat packets -> 0,1,2,3,0
    foreach (exp_grant[i]) ;
    exp_grant.push_back(0);
    exp_grant.push_back(1);
    exp_grant.push_back(2);
    exp_grant.push_back(3);
    exp_grant.push_back(0);
    src_q[0].push_back(1'b1);
    src_q[0].push_back(1'b1);
    for (int s = 1; s < N; s++) src_q[s].push_back(1'b1);
    for (int s = 0; s < N; s++) exp_xfer.push_back('{src: s, last: 1'b1});
    exp_xfer.push_back('{src: 0, last: 1'b1});
    wait_idle("t2");

    // 3: owner 1, three beats under a toggling out_ready
    exp_grant.push_back(1);
    push_pkt(1, 3, 1'b1);
    tick();
    tick();
    chk("t3_busy", 32'(bus.busy), 32'h1);
    for (int k = 0; k < 5; k++) begin
      bus.out_ready = pat[k];
      tick();
    end
    bus.out_ready = 1'b1;
    wait_idle("t3");

    // 4: 20-beat burst from 2 cut at 16, then 3, then 2 finishes
    exp_grant.push_back(2);
    exp_grant.push_back(3);
    exp_grant.push_back(2);
    for (int b = 0; b < 20; b++) src_q[2].push_back(b == 19);
    src_q[3].push_back(1'b1);
    for (int b = 0; b < 16; b++) exp_xfer.push_back('{src: 2, last: 1'b0});
    exp_xfer.push_back('{src: 3, last: 1'b1});
    for (int b = 16; b < 20; b++) exp_xfer.push_back('{src: 2, last: b == 19});
    wait_idle("t4");

    // 5: owner 0 stalls for four cycles while 3 waits
    exp_grant.push_back(0);
    push_pkt(0, 3, 1'b1);
    tick();
    tick();
    chk("t5_grant0", 32'(bus.grant), 32'h1);
    hold[0] = 1'b1;
    exp_grant.push_back(3);
    push_pkt(3, 1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t5_grant_held", 32'(bus.grant), 32'h1);
      chk("t5_out_valid_low", 32'(bus.out_valid), 32'h0);
    end
    hold[0] = 1'b0;
    wait_idle("t5");

    // 6: reset in the middle of a packet from 2, then 1 and 3 request
    exp_grant.push_back(2);
    src_q[2].push_back(1'b0);
    src_q[2].push_back(1'b0);
    src_q[2].push_back(1'b0);
    src_q[2].push_back(1'b1);
    exp_xfer.push_back('{src: 2, last: 1'b0});
    tick();
    tick();
    tick();
    rst = 1'b1;
    src_q[2].delete();
    tick();
    chk("t6_grant", 32'(bus.grant), 32'h0);
    chk("t6_busy", 32'(bus.busy), 32'h0);
    chk("t6_sel", 32'(bus.sel), 32'h0);
    chk("t6_out_valid", 32'(bus.out_valid), 32'h0);
    rst = 1'b0;
    exp_grant.push_back(1);
    exp_grant.push_back(3);
    push_pkt(1, 1, 1'b1);
    push_pkt(3, 1, 1'b1);
    wait_idle("t6");

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, miscompares %0d", miscompares);
    $fatal(1, "watchdog");
  end

endmodule
